// File: rtl/alpha_blend_rmw.sv
`default_nettype none
// ============================================================================
// Module   : alpha_blend_rmw
// Brief    : Single-outstanding read-modify-write alpha blender for the frame
//            buffer path, with frame-completion tracking.
// Revision : 1.0
// ============================================================================
module alpha_blend_rmw #(
  parameter int CH_W    = 8,
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 19,
  parameter int ALPHA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  input  logic [ADDR_W-1:0]        pixel_number,
  input  logic [NUM_CH*CH_W-1:0]   src_data,
  input  logic [ALPHA_W-1:0]       alpha,
  input  logic [1:0]               mode,
  output logic                     read,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_valid,
  input  logic [NUM_CH*CH_W-1:0]   read_data,
  output logic                     write,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NUM_CH*CH_W-1:0]   write_data,
  input  logic                     wr_ack,
  input  logic                     frame_ready,
  output logic                     o_frame_ready
);

  localparam int c_DATA_W = NUM_CH * CH_W;
  localparam int c_IW     = CH_W + ALPHA_W + 1;
  localparam logic [ALPHA_W:0] c_ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};
  localparam logic [1:0] c_MODE_BLEND   = 2'd1;
  localparam logic [1:0] c_MODE_ADD     = 2'd2;
  localparam logic [1:0] c_MODE_DISCARD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CALC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic                 w_pixel_ready, w_read, w_write;
  logic                 w_accept, w_accept_busy, w_done, w_frame_pulse;
  logic [ADDR_W-1:0]    r_addr, r_wr_addr;
  logic [c_DATA_W-1:0]  r_src, r_dst, r_wr_data, w_result;
  logic [ALPHA_W-1:0]   r_alpha;
  logic [1:0]           r_mode;
  logic [ALPHA_W:0]     w_a;
  logic                 r_frame_pending, r_frame_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_pixel_ready = 1'b0;
    w_read        = 1'b0;
    w_write       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pixel_ready = 1'b1;
        if (pixel_valid) begin
          case (mode)
            c_MODE_BLEND, c_MODE_ADD: w_next_state = S_READ;
            c_MODE_DISCARD:           w_next_state = S_IDLE;
            default:                  w_next_state = S_CALC;
          endcase
        end
      end
      S_READ: begin
        w_read = 1'b1;
        if (rd_valid) w_next_state = S_CALC;
      end
      S_CALC: w_next_state = S_WRITE;
      S_WRITE: begin
        w_write = 1'b1;
        if (wr_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept      = pixel_valid && w_pixel_ready;
  assign w_accept_busy = w_accept && (mode != c_MODE_DISCARD);
  assign w_done        = (r_state == S_WRITE) && wr_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_src     <= '0;
      r_alpha   <= '0;
      r_mode    <= '0;
      r_dst     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= pixel_number;
        r_src   <= src_data;
        r_alpha <= alpha;
        r_mode  <= mode;
      end
      if ((r_state == S_READ) && rd_valid) r_dst <= read_data;
      if (r_state == S_CALC) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_result;
      end
    end
  end

  // Alpha of all-ones is promoted to exactly 2^ALPHA_W so the blend endpoints are exact.
  assign w_a = {1'b0, r_alpha} + {{ALPHA_W{1'b0}}, r_alpha[ALPHA_W-1]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CH_W-1:0] w_s, w_d;
    logic [c_IW-1:0] w_blend_full, w_scaled_full;
    logic [CH_W:0]   w_sum;
    logic            w_unused_ch;

    assign w_s           = r_src[g*CH_W +: CH_W];
    assign w_d           = r_dst[g*CH_W +: CH_W];
    assign w_blend_full  = c_IW'(w_s) * c_IW'(w_a) + c_IW'(w_d) * c_IW'(c_ALPHA_ONE - w_a);
    assign w_scaled_full = c_IW'(w_s) * c_IW'(w_a);
    assign w_sum         = {1'b0, w_d} + {1'b0, w_scaled_full[ALPHA_W +: CH_W]};
    assign w_unused_ch   = ^{w_blend_full[ALPHA_W-1:0], w_blend_full[c_IW-1],
                             w_scaled_full[ALPHA_W-1:0], w_scaled_full[c_IW-1]};

    always_comb begin
      case (r_mode)
        c_MODE_BLEND: w_result[g*CH_W +: CH_W] = w_blend_full[ALPHA_W +: CH_W];
        c_MODE_ADD:   w_result[g*CH_W +: CH_W] = w_sum[CH_W] ? {CH_W{1'b1}} : w_sum[CH_W-1:0];
        default:      w_result[g*CH_W +: CH_W] = w_s;
      endcase
    end
  end

  // A frame marker arriving with a busy accept belongs to that pixel, so it waits for its write.
  assign w_frame_pulse = (frame_ready && (r_state == S_IDLE) && !w_accept_busy) ||
                         ((r_frame_pending || frame_ready) && w_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_pending <= 1'b0;
      r_frame_ready   <= 1'b0;
    end else begin
      r_frame_ready <= w_frame_pulse;
      if (w_frame_pulse)    r_frame_pending <= 1'b0;
      else if (frame_ready) r_frame_pending <= 1'b1;
    end
  end

  assign pixel_ready   = w_pixel_ready;
  assign read          = w_read;
  assign rd_addr       = r_addr;
  assign write         = w_write;
  assign wr_addr       = r_wr_addr;
  assign write_data    = r_wr_data;
  assign o_frame_ready = r_frame_ready;

endmodule
`default_nettype wire

// File: tb/tb_alpha_blend_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_alpha_blend_rmw
// Brief    : Directed bench for alpha_blend_rmw with a write scoreboard and a
//            behavioural frame memory with programmable wait states.
// Revision : 1.0
// ============================================================================
module tb_alpha_blend_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [18:0] pixel_number = '0;
  logic [23:0] src_data = '0;
  logic [7:0]  alpha = '0;
  logic [1:0]  mode = '0;
  logic        read;
  logic [18:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [23:0] read_data = '0;
  logic        write;
  logic [18:0] wr_addr;
  logic [23:0] write_data;
  logic        wr_ack = 1'b0;
  logic        frame_ready = 1'b0;
  logic        o_frame_ready;

  alpha_blend_rmw dut (
    .clk(clk), .rst(rst),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_number(pixel_number), .src_data(src_data), .alpha(alpha), .mode(mode),
    .read(read), .rd_addr(rd_addr), .rd_valid(rd_valid), .read_data(read_data),
    .write(write), .wr_addr(wr_addr), .write_data(write_data), .wr_ack(wr_ack),
    .frame_ready(frame_ready), .o_frame_ready(o_frame_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [23:0] mem [int];
  logic [42:0] sb_q [$];
  int rd_delay = 0;
  int wr_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame memory: answers after rd_delay / wr_delay extra request cycles.
  initial begin
    int rd_wait = 0;
    int wr_wait = 0;
    forever begin
      @(negedge clk);
      rd_valid  = 1'b0;
      wr_ack    = 1'b0;
      read_data = '0;
      if (rst) begin
        rd_wait = 0;
        wr_wait = 0;
      end else begin
        if (read) begin
          if (rd_wait >= rd_delay) begin
            rd_valid  = 1'b1;
            read_data = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 24'h0;
            rd_wait   = 0;
          end else rd_wait++;
        end
        if (write) begin
          if (wr_wait >= wr_delay) begin
            wr_ack  = 1'b1;
            wr_wait = 0;
          end else wr_wait++;
        end
      end
    end
  end

  // Scoreboard monitor: every committed write must match the oldest expectation.
  initial begin
    logic [42:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && write && wr_ack) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h required=none", {wr_addr, write_data});
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[42:24]));
          check("write_data", 64'(write_data), 64'(e[23:0]));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic offer(input logic [18:0] a, input logic [23:0] s, input logic [7:0] al,
                       input logic [1:0] m, input bit push, input logic [23:0] exp);
    bit ok;
    ok = 0;
    pixel_number = a; src_data = s; alpha = al; mode = m; pixel_valid = 1'b1;
    if (push) sb_q.push_back({a, exp});
    for (int i = 0; i < 50; i++) begin
      if (pixel_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pixel_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int rc, wc, bad, busy, idx, last_w, pidx, pulses;
    repeat (3) @(negedge clk);
    check("rst_pixel_ready", 64'(pixel_ready), 64'(1));
    check("rst_outputs", 64'({read, write, o_frame_ready}), 64'(0));
    check("rst_addr_data", 64'({rd_addr, wr_addr, write_data}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Blend alpha 0x80: A=129, ch2 = 200*127>>8 = 99
    mem[32'h100] = 24'hC86400;
    offer(19'h100, 24'h0064C8, 8'h80, 2'd1, 1, 24'h636464);
    check("t1_read_c1", 64'({read, write}), 64'(2'b10));
    check("t1_rd_addr", 64'(rd_addr), 64'(19'h100));
    @(negedge clk);
    check("t1_c2_idle_bus", 64'({read, write}), 64'(0));
    @(negedge clk);
    check("t1_write_c3", 64'(write), 64'(1));
    wait_idle();

    mem[32'h101] = 24'h123456;
    offer(19'h101, 24'hABCDEF, 8'h00, 2'd1, 1, 24'h123456);
    wait_idle();
    mem[32'h102] = 24'h123456;
    offer(19'h102, 24'hABCDEF, 8'hFF, 2'd1, 1, 24'hABCDEF);
    wait_idle();
    mem[32'h103] = 24'h000AFA;
    offer(19'h103, 24'hFF1414, 8'hFF, 2'd2, 1, 24'hFF1EFF);
    wait_idle();

    // Replace: no read, write two cycles after accept
    offer(19'h104, 24'h5A5AA5, 8'h40, 2'd0, 1, 24'h5A5AA5);
    check("rep_c1", 64'({read, write}), 64'(0));
    @(negedge clk);
    check("rep_c2", 64'({read, write}), 64'(2'b01));
    wait_idle();

    // Discard together with a frame marker: nothing on the bus, pulse next cycle
    frame_ready = 1'b1;
    offer(19'h105, 24'h111111, 8'h80, 2'd3, 0, 24'h0);
    check("disc_bus", 64'({read, write}), 64'(0));
    check("disc_ready", 64'(pixel_ready), 64'(1));
    check("disc_frame", 64'(o_frame_ready), 64'(1));
    @(negedge clk);
    check("disc_frame_one", 64'(o_frame_ready), 64'(0));

    // Stalls: 4 extra read cycles, 3 extra write cycles; second pixel waits
    rd_delay = 4; wr_delay = 3;
    mem[32'h106] = 24'h000000;
    mem[32'h107] = 24'h010101;
    offer(19'h106, 24'h0000FF, 8'h80, 2'd1, 1, 24'h000080);
    pixel_number = 19'h107; src_data = 24'h020202; alpha = 8'h80; mode = 2'd2;
    pixel_valid = 1'b1;
    sb_q.push_back({19'h107, 24'h020202});
    rc = 0; wc = 0; bad = 0; busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (pixel_ready) break;
      busy++;
      if (read) begin
        rc++;
        if (rd_addr !== 19'h106) bad++;
      end
      if (write) begin
        wc++;
        if (wr_addr !== 19'h106 || write_data !== 24'h000080) bad++;
      end
      @(negedge clk);
    end
    check("stall_read_cycles", 64'(rc), 64'(5));
    check("stall_write_cycles", 64'(wc), 64'(4));
    check("stall_busy_cycles", 64'(busy), 64'(10));
    check("stall_stable", 64'(bad), 64'(0));
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0;
    check("second_read", 64'({read, rd_addr}), 64'({1'b1, 19'h107}));
    wait_idle();

    // Frame marker during a write stall
    rd_delay = 0; wr_delay = 3;
    offer(19'h108, 24'h777777, 8'h00, 2'd0, 1, 24'h777777);
    @(negedge clk);
    frame_ready = 1'b1;
    idx = 2; last_w = write ? 2 : 0; pidx = 0; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      frame_ready = 1'b0;
      idx++;
      if (write) last_w = idx;
      if (o_frame_ready) begin
        pulses++;
        pidx = idx;
      end
    end
    check("frame_pulses", 64'(pulses), 64'(1));
    check("frame_pulse_cycle", 64'(pidx), 64'(last_w + 1));
    wr_delay = 0;

    // Frame marker while idle
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("idle_frame", 64'(o_frame_ready), 64'(1));
    @(negedge clk);
    check("idle_frame_one", 64'(o_frame_ready), 64'(0));

    // Reset while reading abandons the pixel and the pending frame
    rd_delay = 100;
    offer(19'h109, 24'h333333, 8'h80, 2'd1, 0, 24'h0);
    check("rstmid_read", 64'(read), 64'(1));
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_after", 64'({read, pixel_ready}), 64'(2'b01));
    rst = 1'b0;
    rd_delay = 0;
    wc = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (write) wc++;
      if (o_frame_ready) pulses++;
    end
    check("rstmid_no_write", 64'(wc), 64'(0));
    check("rstmid_no_frame", 64'(pulses), 64'(0));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
